// File: rtl/sample_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_mem_arbiter_pkg
// Brief    : Shared types and default sizes for the sample memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sample_mem_arbiter_pkg;

  // Default data-set geometry
  localparam int DEF_N_SAMPLES = 150;
  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 16;

  // Fill level of the sample memory
  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_FULL    = 2'd2
  } fill_state_e;

  // Requester favoured on the next contested cycle
  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

endpackage
`default_nettype wire

// File: rtl/sample_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter (write side vs read side) with a
//            read lock that lets the read side win every contested cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import sample_mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  wr_elig_i,
  input  logic  rd_elig_i,
  input  logic  lock_i,
  output logic  wr_gnt_o,
  output logic  rd_gnt_o,
  output prio_e prio_o
);

  prio_e prio_q;
  prio_e prio_d;
  logic  lock_q;
  prio_e w_prio_eff;
  logic  w_contested;

  assign w_contested = wr_elig_i && rd_elig_i;

  // In the cycle the lock drops the write side is favoured immediately, so
  // the first contested cycle after a locked pass always goes to the loader.
  assign w_prio_eff = (lock_q && !lock_i) ? PRIO_WR : prio_q;

  // Priority pointer and lock history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= PRIO_WR;
      lock_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      lock_q <= lock_i;
    end
  end

  // Next priority: point at the loser of a contested cycle, freeze while locked
  always_comb begin
    prio_d = w_prio_eff;
    if (clr_i) begin
      prio_d = PRIO_WR;
    end else if (lock_i) begin
      prio_d = prio_q;
    end else if (w_contested) begin
      prio_d = (w_prio_eff == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
  end

  // One-hot grant selection
  always_comb begin
    wr_gnt_o = 1'b0;
    rd_gnt_o = 1'b0;
    if (w_contested) begin
      if (lock_i || (w_prio_eff == PRIO_RD)) begin
        rd_gnt_o = 1'b1;
      end else begin
        wr_gnt_o = 1'b1;
      end
    end else begin
      wr_gnt_o = wr_elig_i;
      rd_gnt_o = rd_elig_i;
    end
  end

  assign prio_o = prio_q;

endmodule
`default_nettype wire

// File: rtl/sample_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_mem_arbiter
// Brief    : Shares a single-port synchronous sample memory between the
//            sample loader (writes at an internal fill pointer) and the
//            regression controller (reads by index, stalled until written).
//            Optional macro SAMPLE_MEM_ARB_LOCK_EN enables the rd_lock burst
//            lock; without it rd_lock is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sample_mem_arbiter
  import sample_mem_arbiter_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_adr,
  input  logic          rd_lock,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   fill,
  output logic          full
);

  localparam logic [AW:0] c_fill_max = (AW+1)'(N_SAMPLES);
  localparam logic [AW:0] c_one      = (AW+1)'(1);

  generate
    if (N_SAMPLES > (1 << AW)) begin : g_bad_size
      $error("N_SAMPLES does not fit the address space");
    end
  endgenerate

  fill_state_e   state_q;
  fill_state_e   state_d;
  logic [AW:0]   fill_q;
  logic [AW:0]   fill_d;
  logic [AW-1:0] adr_q;
  logic          rd_valid_q;

  logic          w_lock;
  logic          w_wr_elig;
  logic          w_rd_elig;
  logic          w_rd_written;
  prio_e         w_unused_prio;

`ifdef SAMPLE_MEM_ARB_LOCK_EN
  assign w_lock = rd_lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = rd_lock;
  assign w_lock        = 1'b0;
`endif

  // A read is only legal once its sample has been written; the explicit
  // N_SAMPLES bound keeps out-of-range indices out even if fill misbehaves.
  assign w_rd_written = ({1'b0, rd_adr} < fill_q) && ({1'b0, rd_adr} < c_fill_max);

  // Grants are held off while reset is asserted so the memory sees no strobe.
  assign w_wr_elig = !rst && wr_req && !full && !clr;
  assign w_rd_elig = !rst && rd_req && w_rd_written && !clr;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .wr_elig_i (w_wr_elig),
    .rd_elig_i (w_rd_elig),
    .lock_i    (w_lock),
    .wr_gnt_o  (wr_gnt),
    .rd_gnt_o  (rd_gnt),
    .prio_o    (w_unused_prio)
  );

  // Fill state, fill counter, held address and read-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL_EMPTY;
      fill_q     <= '0;
      adr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      adr_q      <= mem_adr;
      rd_valid_q <= rd_gnt;
    end
  end

  // Next fill state and level: only a granted write or clr moves them
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (clr) begin
      state_d = FILL_EMPTY;
      fill_d  = '0;
    end else if (wr_gnt) begin
      fill_d  = fill_q + c_one;
      state_d = ((fill_q + c_one) == c_fill_max) ? FILL_FULL : FILL_FILLING;
    end
  end

  // Status outputs decoded from the fill state
  always_comb begin
    full = (state_q == FILL_FULL);
    fill = fill_q;
  end

  // Memory address mux; with no grant the last address is held
  always_comb begin
    mem_adr = adr_q;
    if (wr_gnt) begin
      mem_adr = fill_q[AW-1:0];
    end else if (rd_gnt) begin
      mem_adr = rd_adr;
    end
  end

  assign mem_we    = wr_gnt;
  assign mem_wdata = wr_data;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sample_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_mem_arbiter
// Brief    : Directed scoreboard bench for sample_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sample_mem_arbiter;

  localparam int N  = 150;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, clr, wr_req, rd_req, rd_lock;
  logic [DW-1:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] rd_adr, mem_adr;
  logic          wr_gnt, rd_gnt, rd_valid, mem_we, full;
  logic [AW:0]   fill;

  always #5 clk = ~clk;

  sample_mem_arbiter #(.N_SAMPLES(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_adr    (rd_adr),
    .rd_lock   (rd_lock),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fill      (fill),
    .full      (full)
  );

  // Single-port synchronous memory macro stand-in
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_wdata;
    mem_rdata <= mem[mem_adr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr [$];
  logic [DW-1:0] exp_rd [$];

  // Monitor: every memory write and every read return is matched in order
  always @(negedge clk) begin
    wr_t           e;
    logic [DW-1:0] d;
    if (!rst) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {31'd0, mem_we}, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_adr", {24'd0, mem_adr}, {24'd0, e.adr});
          check("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
          d = exp_rd.pop_front();
          check("rd_data", {16'd0, rd_data}, {16'd0, d});
        end
      end
    end
  end

  int            exp_fill;
  logic          prev_rg;
  logic [DW-1:0] shadow [0:255];

  // One clock cycle of stimulus with the hand-derived grant outcome
  task automatic cyc(input logic wr, input logic [DW-1:0] wd, input logic rd,
                     input logic [AW-1:0] ra, input logic cl,
                     input logic ewg, input logic erg, input string nm);
    wr_req  = wr;
    wr_data = wd;
    rd_req  = rd;
    rd_adr  = ra;
    clr     = cl;
    if (ewg) exp_wr.push_back('{AW'(exp_fill), wd});
    if (erg) exp_rd.push_back(shadow[ra]);
    @(negedge clk);
    check({nm, "_wr_gnt"}, {31'd0, wr_gnt}, {31'd0, ewg});
    check({nm, "_rd_gnt"}, {31'd0, rd_gnt}, {31'd0, erg});
    check({nm, "_rd_valid"}, {31'd0, rd_valid}, {31'd0, prev_rg});
    check({nm, "_fill"}, {23'd0, fill}, 32'(exp_fill));
    check({nm, "_full"}, {31'd0, full}, {31'd0, (exp_fill == N)});
    @(posedge clk);
    #1;
    prev_rg = erg;
    if (cl) begin
      exp_fill = 0;
    end else if (ewg) begin
      shadow[exp_fill] = wd;
      exp_fill++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wr_req = 1'b1; rd_req = 1'b1; rd_adr = '0;
    wr_data = '0; rd_lock = 1'b0; exp_fill = 0; prev_rg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with both requesters asking
    check("rst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    check("rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_adr", {24'd0, mem_adr}, 32'd0);
    check("rst_fill", {23'd0, fill}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load a full data set, data = index
    for (int i = 0; i < N; i++) cyc(1'b1, 16'(i), 1'b0, '0, 1'b0, 1'b1, 1'b0, "load");
    cyc(1'b1, 16'hDEAD, 1'b0, '0, 1'b0, 1'b0, 1'b0, "load_over");
    check("adr_hold", {24'd0, mem_adr}, 32'd149);
    cyc(1'b0, '0, 1'b1, 8'd150, 1'b0, 1'b0, 1'b0, "rd_oob");
    cyc(1'b1, 16'hBEEF, 1'b1, 8'd149, 1'b0, 1'b0, 1'b1, "rd_last");

    // clr right after a read grant; that read still returns
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "clr_after_rd");

    // Early read stall
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, '0, 1'b0, 1'b1, 1'b0, "pre");
    for (int i = 3; i < 6; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b1, 8'd5, 1'b0, 1'b1, 1'b0, "stall");
    cyc(1'b0, '0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, "stall_rel");
    for (int i = 6; i < 10; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, '0, 1'b0, 1'b1, 1'b0, "pre10");

    // Contention at fill = 10: WR, RD, WR, RD, WR, RD
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 16'hB000 + 16'(k), 1'b1, AW'(k / 2), 1'b0, (k % 2) == 0, (k % 2) == 1, "contend");

`ifdef SAMPLE_MEM_ARB_LOCK_EN
    // Leave prio at RD, then a locked pass, then the unlock cycle goes to WR
    cyc(1'b1, 16'hC0FF, 1'b1, '0, 1'b0, 1'b1, 1'b0, "prelock");
    rd_lock = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b1, 16'hC000 + 16'(k), 1'b1, AW'(k), 1'b0, 1'b0, 1'b1, "lock");
    rd_lock = 1'b0;
    cyc(1'b1, 16'hC100, 1'b1, '0, 1'b0, 1'b1, 1'b0, "unlock_wr");
    cyc(1'b1, 16'hC101, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, "unlock_rd");
`endif

    // Fill to 80, last write contested so prio ends on RD
    while (exp_fill < 79) cyc(1'b1, 16'(exp_fill) ^ 16'h5A5A, 1'b0, '0, 1'b0, 1'b1, 1'b0, "fill80");
    cyc(1'b1, 16'h7777, 1'b1, '0, 1'b0, 1'b1, 1'b0, "c79");

    // clr with wr_req: write dropped, fill 0, read stalls, prio back to WR
    cyc(1'b1, 16'h8888, 1'b1, '0, 1'b1, 1'b0, 1'b0, "clr_wr");
    cyc(1'b0, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0, "clr_stall");
    cyc(1'b1, 16'h1111, 1'b1, '0, 1'b0, 1'b1, 1'b0, "post_clr_w");
    cyc(1'b1, 16'h2222, 1'b1, '0, 1'b0, 1'b1, 1'b0, "post_clr_prio");
    cyc(1'b1, 16'h3333, 1'b1, '0, 1'b0, 1'b0, 1'b1, "post_clr_rr");

    // Async reset one cycle after a read grant
    wr_req = 1'b0; rd_req = 1'b1; rd_adr = 8'd1; clr = 1'b0;
    @(negedge clk);
    check("burst_rd_gnt", {31'd0, rd_gnt}, 32'd1);
    check("burst_rd_valid", {31'd0, rd_valid}, {31'd0, prev_rg});
    @(posedge clk);
    #1;
    check("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
    wr_req = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_fill", {23'd0, fill}, 32'd0);
    check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_mem_adr", {24'd0, mem_adr}, 32'd0);
    check("mid_rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    exp_fill = 0; prev_rg = 1'b0;

    cyc(1'b1, 16'h4444, 1'b0, '0, 1'b0, 1'b1, 1'b0, "after_rst_w");
    cyc(1'b0, '0, 1'b1, '0, 1'b0, 1'b0, 1'b1, "after_rst_rd");
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "idle");

    check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_left", 32'(exp_rd.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_mem_arbiter.md
# sample_mem_arbiter

Shares the single-port synchronous sample memory of the regression unit between two requesters: the sample loader, which streams write data in, and the regression controller, which reads samples by address. The arbiter generates the write address internally as a fill pointer, tracks how many samples are valid, and stalls reads of samples not yet written, so computation may overlap loading. It sits between the loader, the controller's address output and the memory macro.

## Interface
- N_SAMPLES, 150: samples per data set; maximum fill level.
- AW, 8: memory address width; requires N_SAMPLES <= 2**AW.
- DW, 16: sample word width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of fill level; data set restart.
- wr_req  in  1  loader has a word on wr_data.
- wr_data  in  DW  sample word.
- wr_gnt  out  1  combinational; word accepted this cycle.
- rd_req  in  1  controller requests sample rd_adr.
- rd_adr  in  AW  sample index, 0-based.
- rd_lock  in  1  controller burst lock (see Configuration).
- rd_gnt  out  1  combinational; read issued this cycle.
- rd_valid  out  1  registered; rd_data valid, one cycle after rd_gnt.
- rd_data  out  DW  equals mem_rdata.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, registered inside the macro.
- fill  out  AW+1  count of valid samples.
- full  out  1  fill == N_SAMPLES.

## Operation
- Fill states: EMPTY (fill=0), FILLING (0<fill<N_SAMPLES), FULL. Transitions occur only on a granted write or clr; clr from any state returns to EMPTY.
- Write eligibility: wr_req && !full && !clr.
- Read eligibility: rd_req && rd_adr < fill && !clr. A read of an index >= fill stalls (rd_gnt=0) until that sample is written. rd_adr >= N_SAMPLES is never granted.
- At most one grant per cycle. When only one requester is eligible, it is granted.
- When both are eligible, the winner is selected by the priority pointer prio. prio is WR after reset and after clr. After each contested cycle, prio points to the loser, giving round-robin arbitration. An uncontested grant leaves prio unchanged.
- Write grant: mem_we=1, mem_adr=fill[AW-1:0], mem_wdata=wr_data. fill increments at the edge.
- Read grant: mem_we=0, mem_adr=rd_adr.
- No grant: mem_we=0, mem_adr holds its previous value (register).
- A write into slot k and a read of slot k are never issued in the same cycle, because the read requires rd_adr < fill.

## Timing
- Reset values: wr_gnt=0, rd_gnt=0, rd_valid=0, mem_we=0, mem_adr=0, fill=0, full=0, prio=WR.
- Grant decision: zero latency. Requesters sample the grant in the same cycle and advance on gnt.
- Read latency: rd_valid is high exactly one cycle after rd_gnt. Back-to-back grants give one rd_valid per cycle.
- full rises on the edge that accepts write number N_SAMPLES.
- clr together with wr_req: the write is dropped and fill becomes 0. A clr in the cycle after a read grant does not suppress rd_valid.
- rst mid-burst: all state returns to reset values and any pending rd_valid is cancelled.

## Configuration
- SAMPLE_MEM_ARB_LOCK_EN defined: while rd_lock=1, an eligible read always beats a write, and prio is not updated. When rd_lock falls, prio is set to WR. This lets the controller run an uninterrupted pass over the samples.
- SAMPLE_MEM_ARB_LOCK_EN undefined: rd_lock is ignored and arbitration is pure round-robin.

## Structure
- Shared package: fill-state encoding (EMPTY, FILLING, FULL), prio encoding (WR, RD), and default constants N_SAMPLES, AW and DW.
- One sub-module: rr_arb2, a 2-way round-robin arbiter. Inputs are two eligibility lines and a lock line; outputs are one-hot grants plus the prio register.
- The fill counter, address mux and rd_valid register live in the top module.

## Test plan
- Load only: after reset, 150 wr_req cycles with data = index -> mem_adr 0..149, full rises after write 150, and a 151st wr_req is not granted.
- Early read stall: fill=3, rd_adr=5 held -> rd_gnt=0 until fill=6. rd_gnt is granted in the cycle fill becomes 6, with rd_valid the next cycle.
- Contention: fill=10, wr_req and rd_req held for 6 cycles -> grants alternate WR, RD, WR, RD, WR, RD, and rd_valid follows each RD grant by one cycle.
- Lock (macro defined): rd_lock=1 with both requesting for 5 cycles -> 5 read grants and 0 write grants. The first contested cycle after rd_lock falls grants WR.
- clr with wr_req at fill=80 -> write dropped, fill=0, prio=WR, and a pending rd_req at rd_adr=0 stalls.
- Async rst asserted mid-burst, one cycle after rd_gnt -> rd_valid=0 immediately, fill=0, and mem_we=0.
